// File: rtl/doc_hw_window_monitor.sv
// Per-channel signed window monitor with debounce and sticky fault flags.
// Optional missing-sample (stale) detection is built when DOC_HW_STALE_CHECK_EN is defined.
module doc_hw_window_monitor #(
   parameter int unsigned P_NO_CHANNELS      = 9,
   parameter int unsigned P_NO_TEMP_CHANNELS = 5,
   parameter int unsigned P_DATA_W           = 32,
   parameter int unsigned P_CH_W             = 4,
   parameter int          P_MAX_TEMP_HW      = 60,
   parameter int          P_MIN_TEMP_HW      = 0,
   parameter int unsigned P_DEBOUNCE         = 4,
   parameter int unsigned P_TIMEOUT          = 1024
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   input  logic [P_CH_W-1:0]        in_channel,
   input  logic [P_DATA_W-1:0]      in_data,
   input  logic                     cfg_wr,
   input  logic [P_CH_W-1:0]        cfg_ch,
   input  logic                     cfg_sel,
   input  logic [P_DATA_W-1:0]      cfg_data,
   input  logic                     clr,
   input  logic [P_NO_CHANNELS-1:0] clr_mask,
   output logic [P_NO_CHANNELS-1:0] fault,
   output logic [P_NO_CHANNELS-1:0] stale,
   output logic                     fault_any,
   output logic                     err_bad_ch
);

   localparam logic [P_CH_W:0]          LP_NCH      = P_NO_CHANNELS[P_CH_W:0];
   localparam logic signed [P_DATA_W-1:0] LP_TMAX   = P_DATA_W'(P_MAX_TEMP_HW);
   localparam logic signed [P_DATA_W-1:0] LP_TMIN   = P_DATA_W'(P_MIN_TEMP_HW);
   localparam logic signed [P_DATA_W-1:0] LP_MOSTNEG = {1'b1, {(P_DATA_W-1){1'b0}}};
   localparam logic signed [P_DATA_W-1:0] LP_MOSTPOS = {1'b0, {(P_DATA_W-1){1'b1}}};
   localparam logic [7:0]               LP_DEB      = 8'(P_DEBOUNCE);
`ifdef DOC_HW_STALE_CHECK_EN
   localparam int unsigned              LP_TW       = $clog2(P_TIMEOUT + 1);
   localparam logic [LP_TW-1:0]         LP_TMO      = LP_TW'(P_TIMEOUT);
`endif

   logic w_in_ok;
   logic w_cfg_ok;
   logic w_bad;
   logic r_any;
   logic r_err;

   assign w_in_ok  = in_valid & ({1'b0, in_channel} < LP_NCH);
   assign w_cfg_ok = cfg_wr & ({1'b0, cfg_ch} < LP_NCH);
   assign w_bad    = (in_valid & ~w_in_ok) | (cfg_wr & ~w_cfg_ok);

   for (genvar g = 0; g < P_NO_CHANNELS; g++) begin : g_ch
      localparam int unsigned        LP_GI = g;
      localparam logic [P_CH_W-1:0]  LP_G  = LP_GI[P_CH_W-1:0];

      logic signed [P_DATA_W-1:0] w_lo;
      logic signed [P_DATA_W-1:0] w_hi;
      logic                       w_clr;
      logic                       w_sel;
      logic                       w_viol;
      logic [7:0]                 r_cnt;
      logic                       r_fault;

      assign w_clr = clr & clr_mask[g];
      // a cleared channel discards its same-cycle sample
      assign w_sel = w_in_ok & (in_channel == LP_G) & ~w_clr;

      if (LP_GI < P_NO_TEMP_CHANNELS) begin : g_temp
         assign w_lo = LP_TMIN;
         assign w_hi = LP_TMAX;
      end else begin : g_prog
         logic signed [P_DATA_W-1:0] r_lo;
         logic signed [P_DATA_W-1:0] r_hi;
         logic                       w_wr;

         assign w_wr = w_cfg_ok & (cfg_ch == LP_G);

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_lo <= LP_MOSTNEG;
               r_hi <= LP_MOSTPOS;
            end else if (w_wr) begin
               if (cfg_sel) r_hi <= cfg_data;
               else         r_lo <= cfg_data;
            end
         end

         assign w_lo = r_lo;
         assign w_hi = r_hi;
      end

      assign w_viol = ($signed(in_data) < w_lo) || ($signed(in_data) > w_hi);

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_cnt   <= '0;
            r_fault <= 1'b0;
         end else if (w_clr) begin
            r_cnt   <= '0;
            r_fault <= 1'b0;
         end else begin
            if (r_cnt == LP_DEB) r_fault <= 1'b1;
            if (w_sel) begin
               if (!w_viol)              r_cnt <= '0;
               else if (r_cnt < LP_DEB)  r_cnt <= r_cnt + 8'd1;
            end
         end
      end

      assign fault[g] = r_fault;

`ifdef DOC_HW_STALE_CHECK_EN
      logic [LP_TW-1:0] r_tmr;
      logic             r_stale;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_tmr   <= '0;
            r_stale <= 1'b0;
         end else if (w_clr) begin
            r_tmr   <= '0;
            r_stale <= 1'b0;
         end else if (w_sel) begin
            r_tmr   <= '0;
         end else if (r_tmr == LP_TMO) begin
            r_stale <= 1'b1;
         end else begin
            r_tmr   <= r_tmr + LP_TW'(1);
         end
      end

      assign stale[g] = r_stale;
`else
      assign stale[g] = 1'b0;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_any <= 1'b0;
         r_err <= 1'b0;
      end else begin
         r_any <= |(fault | stale);
         if (w_bad)                  r_err <= 1'b1;
         else if (clr && &clr_mask)  r_err <= 1'b0;
      end
   end

   assign fault_any  = r_any;
   assign err_bad_ch = r_err;

endmodule

// File: tb/tb_doc_hw_window_monitor.sv
// Directed plus randomized bench for doc_hw_window_monitor against a history-based model.
// Stale checks follow DOC_HW_STALE_CHECK_EN when it is defined for the build.
module tb_doc_hw_window_monitor;

   localparam int NCH = 9;
   localparam int NTEMP = 5;
   localparam int DEB = 4;
   localparam int TMO = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid = 1'b0;
   logic [3:0]  in_channel = '0;
   logic [31:0] in_data = '0;
   logic        cfg_wr = 1'b0;
   logic [3:0]  cfg_ch = '0;
   logic        cfg_sel = 1'b0;
   logic [31:0] cfg_data = '0;
   logic        clr = 1'b0;
   logic [8:0]  clr_mask = '0;
   logic [8:0]  fault;
   logic [8:0]  stale;
   logic        fault_any;
   logic        err_bad_ch;

   always #5 clk = ~clk;

   doc_hw_window_monitor #(
      .P_NO_CHANNELS(9), .P_NO_TEMP_CHANNELS(5), .P_DATA_W(32), .P_CH_W(4),
      .P_MAX_TEMP_HW(60), .P_MIN_TEMP_HW(0), .P_DEBOUNCE(4), .P_TIMEOUT(16)
   ) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_channel(in_channel),
      .in_data(in_data), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_sel(cfg_sel),
      .cfg_data(cfg_data), .clr(clr), .clr_mask(clr_mask), .fault(fault),
      .stale(stale), .fault_any(fault_any), .err_bad_ch(err_bad_ch)
   );

   int checks = 0;
   int errors = 0;

   // model: run length of violations, edge at which the run first reached DEB,
   // edge of the last sample/clear, and an edge counter since reset release
   int          m_run[NCH];
   int          m_reach[NCH];
   int          m_ls[NCH];
   int          m_lo[NCH];
   int          m_hi[NCH];
   logic [8:0]  m_stv;
   logic        m_err;
   logic        m_any;
   int          m_n;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [8:0] fvec(input int m);
      logic [8:0] r;
      r = '0;
      for (int c = 0; c < NCH; c++) r[c] = (m_reach[c] >= 0) && (m_reach[c] < m);
      return r;
   endfunction

   task automatic model_reset();
      for (int c = 0; c < NCH; c++) begin
         m_run[c] = 0; m_reach[c] = -1; m_ls[c] = 0;
         m_lo[c] = (c < NTEMP) ? 0  : 32'sh8000_0000;
         m_hi[c] = (c < NTEMP) ? 60 : 32'sh7FFF_FFFF;
      end
      m_stv = '0; m_err = 1'b0; m_any = 1'b0; m_n = 0;
   endtask

   task automatic step(input bit v, input int ch, input int d, input bit cw, input int cch,
                       input bit cs, input int cd, input bit c, input logic [8:0] cm);
      logic [8:0] prev;
      bit bad, clrc, samp;
      in_valid = v; in_channel = ch[3:0]; in_data = d;
      cfg_wr = cw; cfg_ch = cch[3:0]; cfg_sel = cs; cfg_data = cd;
      clr = c; clr_mask = cm;
      @(posedge clk);
      prev = fvec(m_n) | m_stv;
      m_n++;
      bad = (v && ch >= NCH) || (cw && cch >= NCH);
      for (int k = 0; k < NCH; k++) begin
         clrc = c && cm[k];
         samp = v && (ch == k) && !clrc;
         if (clrc) begin
            m_run[k] = 0; m_reach[k] = -1; m_stv[k] = 1'b0; m_ls[k] = m_n;
         end else if (samp) begin
            if (d < m_lo[k] || d > m_hi[k]) m_run[k] = (m_run[k] + 1 > DEB) ? DEB : m_run[k] + 1;
            else                            m_run[k] = 0;
            if (m_run[k] == DEB && m_reach[k] < 0) m_reach[k] = m_n;
            m_ls[k] = m_n;
         end else begin
`ifdef DOC_HW_STALE_CHECK_EN
            if ((m_n - 1 - m_ls[k]) >= TMO) m_stv[k] = 1'b1;
`endif
         end
      end
      if (cw && cch >= NTEMP && cch < NCH) begin
         if (cs) m_hi[cch] = cd;
         else    m_lo[cch] = cd;
      end
      if (bad) m_err = 1'b1;
      else if (c && cm == 9'h1FF) m_err = 1'b0;
      m_any = |prev;
      #1;
      chk("fault", {23'd0, fault}, {23'd0, fvec(m_n)});
      chk("stale", {23'd0, stale}, {23'd0, m_stv});
      chk("fault_any", {31'd0, fault_any}, {31'd0, m_any});
      chk("err_bad_ch", {31'd0, err_bad_ch}, {31'd0, m_err});
      in_valid = 1'b0; cfg_wr = 1'b0; clr = 1'b0; clr_mask = '0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, '0);
   endtask
   task automatic smp(input int ch, input int d);
      step(1, ch, d, 0, 0, 0, 0, 0, '0);
   endtask
   task automatic cfg(input int ch, input bit sel, input int d);
      step(0, 0, 0, 1, ch, sel, d, 0, '0);
   endtask
   task automatic clear(input logic [8:0] m);
      step(0, 0, 0, 0, 0, 0, 0, 1, m);
   endtask

   initial begin
      model_reset();
      #2 rst_n = 1'b0;
      #1;
      chk("rst_fault", {23'd0, fault}, 32'd0);
      chk("rst_stale", {23'd0, stale}, 32'd0);
      chk("rst_any", {31'd0, fault_any}, 32'd0);
      chk("rst_err", {31'd0, err_bad_ch}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_reset();

      // programmable channel 6 window and debounce
      cfg(6, 0, 100); cfg(6, 1, 200);
      smp(6, 150);
      chk("ch6_inwin", {31'd0, fault[6]}, 32'd0);
      repeat (4) smp(6, 99);
      chk("ch6_before_lat", {31'd0, fault[6]}, 32'd0);
      idle(1);
      chk("ch6_set", {31'd0, fault[6]}, 32'd1);
      idle(1);
      chk("ch6_any", {31'd0, fault_any}, 32'd1);
      clear(9'h040);
      chk("ch6_clr", {31'd0, fault[6]}, 32'd0);
      smp(6, 201); smp(6, 201); smp(6, 150); smp(6, 201); idle(2);
      chk("ch6_broken_run", {31'd0, fault[6]}, 32'd0);
      smp(6, 200); smp(6, 100); idle(1);
      chk("ch6_limits_incl", {31'd0, fault[6]}, 32'd0);

      // fixed temperature limits
      repeat (4) smp(2, 60); idle(1);
      chk("t2_at_max", {31'd0, fault[2]}, 32'd0);
      repeat (4) smp(2, 61); idle(1);
      chk("t2_over", {31'd0, fault[2]}, 32'd1);
      repeat (4) smp(3, -1); idle(1);
      chk("t3_under", {31'd0, fault[3]}, 32'd1);
      clear(9'h00C);
      cfg(2, 0, 100); cfg(2, 1, 10);
      chk("t2_cfg_noerr", {31'd0, err_bad_ch}, 32'd0);
      repeat (4) smp(2, 30); idle(1);
      chk("t2_cfg_ignored", {31'd0, fault[2]}, 32'd0);

      // bad index handling
      smp(12, 5);
      chk("bad_sample_err", {31'd0, err_bad_ch}, 32'd1);
      chk("bad_no_fault", {23'd0, fault}, 32'd0);
      clear(9'h0FF);
      chk("err_partial_clr", {31'd0, err_bad_ch}, 32'd1);
      clear(9'h1FF);
      chk("err_full_clr", {31'd0, err_bad_ch}, 32'd0);
      cfg(11, 1, 5);
      chk("bad_cfg_err", {31'd0, err_bad_ch}, 32'd1);
      clear(9'h1FF);

      // clear beats a same-cycle sample
      cfg(7, 1, 10);
      repeat (3) smp(7, 20);
      step(1, 7, 20, 0, 0, 0, 0, 1, 9'h080);
      idle(1);
      chk("ch7_clr_pri", {31'd0, fault[7]}, 32'd0);
      repeat (3) smp(7, 20); idle(1);
      chk("ch7_cnt_zeroed", {31'd0, fault[7]}, 32'd0);
      smp(7, 20); idle(1);
      chk("ch7_refault", {31'd0, fault[7]}, 32'd1);

      // same-cycle config uses the old limit
      cfg(5, 1, 100);
      step(1, 5, 80, 1, 5, 1, 50, 0, '0);
      repeat (3) smp(5, 80); idle(1);
      chk("ch5_old_limit", {31'd0, fault[5]}, 32'd0);
      smp(5, 80); idle(1);
      chk("ch5_new_limit", {31'd0, fault[5]}, 32'd1);

      // missing-sample detection on channel 4
      clear(9'h1FF);
      for (int i = 0; i < 4; i++) begin
         smp(4, 30); idle(9);
      end
`ifdef DOC_HW_STALE_CHECK_EN
      chk("ch4_fed", {31'd0, stale[4]}, 32'd0);
      idle(20);
      chk("ch4_stale", {31'd0, stale[4]}, 32'd1);
`else
      idle(20);
      chk("stale_off", {23'd0, stale}, 32'd0);
`endif
      clear(9'h1FF);

      // randomized traffic
      for (int i = 0; i < 800; i++) begin
         int ch, d, cch, cd, r;
         bit v, cw, c;
         logic [8:0] cm;
         v   = ($urandom_range(0, 99) < 75);
         ch  = ($urandom_range(0, 99) < 3) ? 12 : int'($urandom_range(0, 8));
         d   = int'($urandom_range(0, 260)) - 30;
         cw  = ($urandom_range(0, 99) < 10);
         cch = ($urandom_range(0, 99) < 5) ? 10 : int'($urandom_range(0, 8));
         cd  = int'($urandom_range(0, 200));
         r   = int'($urandom_range(0, 99));
         c   = (r < 5);
         cm  = (r < 2) ? 9'h1FF : 9'($urandom_range(0, 511));
         step(v, ch, d, cw, cch, $urandom_range(0, 1) == 1, cd, c, cm);
      end

      // asynchronous reset mid-operation
      repeat (4) smp(8, 1000);
      cfg(8, 1, -5);
      repeat (5) smp(8, 0);
      smp(12, 0);
      rst_n = 1'b0;
      #1;
      chk("arst_fault", {23'd0, fault}, 32'd0);
      chk("arst_stale", {23'd0, stale}, 32'd0);
      chk("arst_any", {31'd0, fault_any}, 32'd0);
      chk("arst_err", {31'd0, err_bad_ch}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      repeat (4) smp(8, 0); idle(1);
      chk("arst_limits", {31'd0, fault[8]}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
